// File: rtl/rsa_modexp_unit.sv
// rsa_modexp_unit
//   Computes cipher_text = plain_text^exp_e mod mod_n. It uses a left-to-right
//   square-and-always-multiply loop over a bit-serial interleaved modular
//   multiplier. Latency does not depend on the data: 2*WIDTH*WIDTH enabled
//   edges from the start edge to the DONE entry edge.
//
// Ports
//   clk          system clock
//   rstb         asynchronous active-low reset
//   ena          clock enable; all registers hold while low
//   en_rsa       unit enable from the RSA enable controller
//   rst_rsa      unit soft reset, active low
//   plain_text   message M, captured on the start edge
//   exp_e        exponent E, captured on the start edge
//   mod_n        modulus N, captured on the start edge
//   cipher_text  result register
//   op_err       last run had illegal operands (N<2 or M>=N)
//   eoc_rsa_unit end of conversion, a level held while in DONE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for en_rsa=1 and rst_rsa=1; operands captured on exit
// SQR   | R*R mod N, one bit of A per cycle
// MUL   | R*M mod N, always executed; the result is kept only if E[i]=1
// DONE  | result valid, eoc_rsa_unit=1 until an abort condition occurs

module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exp_e,
  input  logic [WIDTH-1:0] mod_n,
  output logic [WIDTH-1:0] cipher_text,
  output logic             op_err,
  output logic             eoc_rsa_unit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_q, e_q, n_q, r_q;
  logic [WIDTH+1:0] p_q;
  logic [CW-1:0]    i_q, j_q;

  logic [WIDTH-1:0] mul_a, mul_b, r_new;
  logic [WIDTH+1:0] n_ext, p_dbl, p_s1, p_nxt;
  logic             illegal, go;

  // One multiplier step: P <- 2P + A[j]*B, then reduce. With P<N and B<N the
  // sum is below 3N, so two conditional subtractions restore P<N. WIDTH+2 bits
  // hold 3N without overflow.
  always_comb begin
    mul_a   = r_q;
    mul_b   = (state == MUL) ? m_q : r_q;
    n_ext   = {2'b00, n_q};
    p_dbl   = {p_q[WIDTH:0], 1'b0} + (mul_a[j_q] ? {2'b00, mul_b} : '0);
    p_s1    = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
    p_nxt   = (p_s1 >= n_ext) ? (p_s1 - n_ext) : p_s1;
    r_new   = e_q[i_q] ? p_nxt[WIDTH-1:0] : r_q;
    illegal = (n_q < WIDTH'(2)) || (m_q >= n_q);
    go      = en_rsa && rst_rsa;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      m_q          <= '0;
      e_q          <= '0;
      n_q          <= '0;
      r_q          <= '0;
      p_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      cipher_text  <= '0;
      op_err       <= 1'b0;
      eoc_rsa_unit <= 1'b0;
    end else if (ena) begin
      if (!go) begin
        // Abort wins over everything; results are kept.
        state        <= IDLE;
        eoc_rsa_unit <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            m_q   <= plain_text;
            e_q   <= exp_e;
            n_q   <= mod_n;
            r_q   <= WIDTH'(1);
            p_q   <= '0;
            i_q   <= TOP;
            j_q   <= TOP;
            state <= SQR;
          end
          SQR: begin
            p_q <= p_nxt;
            j_q <= j_q - CW'(1);
            if (j_q == '0) begin
              r_q   <= p_nxt[WIDTH-1:0];
              p_q   <= '0;
              j_q   <= TOP;
              state <= MUL;
            end
          end
          MUL: begin
            p_q <= p_nxt;
            j_q <= j_q - CW'(1);
            if (j_q == '0) begin
              r_q <= r_new;
              p_q <= '0;
              j_q <= TOP;
              if (i_q != '0) begin
                i_q   <= i_q - CW'(1);
                state <= SQR;
              end else begin
                state        <= DONE;
                cipher_text  <= illegal ? '0 : r_new;
                op_err       <= illegal;
                eoc_rsa_unit <= 1'b1;
              end
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
module tb_rsa_modexp_unit;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] ct;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstb;
  logic         ena;
  logic         en_rsa;
  logic         rst_rsa;
  logic [W-1:0] plain_text;
  logic [W-1:0] exp_e;
  logic [W-1:0] mod_n;
  logic [W-1:0] cipher_text;
  logic         op_err;
  logic         eoc_rsa_unit;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];
  logic [W-1:0] last_ct;

  always #5 clk = ~clk;

  rsa_modexp_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .en_rsa      (en_rsa),
    .rst_rsa     (rst_rsa),
    .plain_text  (plain_text),
    .exp_e       (exp_e),
    .mod_n       (mod_n),
    .cipher_text (cipher_text),
    .op_err      (op_err),
    .eoc_rsa_unit(eoc_rsa_unit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain arithmetic reference for M^E mod N.
  function automatic exp_t model(input int m, input int e, input int n);
    exp_t x;
    int   r;
    x.err = (n < 2) || (m >= n);
    r = 1;
    if (!x.err) begin
      for (int i = W - 1; i >= 0; i--) begin
        r = (r * r) % n;
        if (e[i]) r = (r * m) % n;
      end
    end
    x.ct = x.err ? '0 : W'(r);
    return x;
  endfunction

  // Controller handshake: EN cycle (rst=0) then release; the release edge is T0.
  // Operand inputs are scrambled after T0 to prove they are captured only once.
  task automatic start_run(input int m, input int e, input int n);
    @(negedge clk);
    ena        = 1'b1;
    plain_text = W'(m);
    exp_e      = W'(e);
    mod_n      = W'(n);
    en_rsa     = 1'b1;
    rst_rsa    = 1'b0;
    @(negedge clk);
    rst_rsa = 1'b1;
    sb_q.push_back(model(m, e, n));
    @(posedge clk);
    #1;
    plain_text = W'($urandom);
    exp_e      = W'($urandom);
    mod_n      = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int stall_at, input int stall_len);
    int   edges;
    exp_t x;
    edges = 0;
    while (edges < 400) begin
      @(negedge clk);
      ena = !(edges >= stall_at && edges < stall_at + stall_len);
      @(posedge clk);
      edges++;
      #1;
      if (eoc_rsa_unit) break;
    end
    ena = 1'b1;
    check({tag, "_latency"}, edges, 2 * W * W + stall_len);
    x = sb_q.pop_front();
    check({tag, "_cipher"}, cipher_text, x.ct);
    check({tag, "_op_err"}, op_err, x.err);
    last_ct = x.ct;
  endtask

  // Controller drops rst_rsa after EOC; the unit must leave DONE and hold its result.
  task automatic end_run(input string tag);
    @(negedge clk);
    rst_rsa = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_eoc_fall"}, eoc_rsa_unit, 0);
    check({tag, "_held"}, cipher_text, last_ct);
  endtask

  task automatic full_run(input string tag, input int m, input int e, input int n);
    start_run(m, e, n);
    wait_done(tag, 1000, 0);
    end_run(tag);
  endtask

  initial begin
    exp_t dummy;
    int   stall_at;
    rstb       = 1'b1;
    ena        = 1'b1;
    en_rsa     = 1'b0;
    rst_rsa    = 1'b0;
    plain_text = '0;
    exp_e      = '0;
    mod_n      = '0;
    last_ct    = '0;
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cipher", cipher_text, 0);
    check("rst_op_err", op_err, 0);
    check("rst_eoc", eoc_rsa_unit, 0);
    @(negedge clk);
    rstb = 1'b1;

    full_run("v_2_7_33", 2, 7, 33);
    full_run("v_4_13_97", 4, 13, 97);
    full_run("v_2_255_251", 2, 255, 251);
    full_run("v_254_1_255", 254, 1, 255);
    full_run("v_0_0_33", 0, 0, 33);

    full_run("ill_m_ge_n", 40, 3, 33);
    full_run("ill_n_1", 5, 3, 1);
    full_run("legal_clears_err", 4, 13, 97);

    // Soft abort at T0+50; a missed abort would reach DONE inside the hold window.
    start_run(2, 7, 33);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_rsa = 1'b0;
    @(posedge clk);
    #1;
    check("abort_eoc", eoc_rsa_unit, 0);
    check("abort_cipher", cipher_text, last_ct);
    repeat (100) @(posedge clk);
    #1;
    check("abort_hold_eoc", eoc_rsa_unit, 0);
    check("abort_hold_cipher", cipher_text, last_ct);
    dummy = sb_q.pop_front();
    full_run("restart_2_7_33", 2, 7, 33);

    stall_at = $urandom_range(20, 100);
    start_run(4, 13, 97);
    wait_done("stall", stall_at, 10);
    end_run("stall");

    full_run("ill_before_rst", 40, 3, 33);
    start_run(2, 7, 33);
    repeat (30) @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("hard_rst_cipher", cipher_text, 0);
    check("hard_rst_op_err", op_err, 0);
    check("hard_rst_eoc", eoc_rsa_unit, 0);
    dummy = sb_q.pop_front();
    @(negedge clk);
    en_rsa  = 1'b0;
    rst_rsa = 1'b0;
    rstb    = 1'b1;
    full_run("after_rst", 254, 1, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
